// File: rtl/fp32_pkg.sv
// ============================================================================
// Module      : fp32_pkg
// Description : Shared float32 field widths, constants and field typedef.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp32_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int EXP_MAX = 255;
  localparam int BIAS    = 127;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] INF  = 32'h7F80_0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
  } fp32_t;

endpackage

`default_nettype wire

// File: rtl/leading_zero_counter_25.sv
// ============================================================================
// Module      : leading_zero_counter_25
// Description : Combinational leading-zero count of a 25-bit word (25 if zero).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module leading_zero_counter_25 (
  input  logic [24:0] i_value,
  output logic [4:0]  o_count
);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    o_count = 5'd25;
    for (int i = 0; i < 25; i++) begin
      if (i_value[i]) o_count = 5'(24 - i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/normalize_round_for_floating_point32.sv
// ============================================================================
// Module      : normalize_round_for_floating_point32
// Description : Float32 add/sub final stage: renormalize, RNE round, pack.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module normalize_round_for_floating_point32 #(
  parameter int EXP_W   = fp32_pkg::EXP_W,
  parameter int MAN_W   = fp32_pkg::MAN_W,
  parameter int EXP_MAX = fp32_pkg::EXP_MAX
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic                 sign,
  input  logic [EXP_W-1:0]     exponent,
  input  logic [MAN_W+1:0]     adder_value,
  output logic                 valid_out,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int LZ_W = 5;
  localparam logic signed [EXP_W+1:0] c_exp_max = (EXP_W+2)'(EXP_MAX);

  logic [LZ_W-1:0] w_lz;

  leading_zero_counter_25 u_lzc (
    .i_value (adder_value),
    .o_count (w_lz)
  );

  logic             r1_valid;
  logic             r1_sign;
  logic [EXP_W-1:0] r1_exp;
  logic [MAN_W+1:0] r1_value;
  logic [LZ_W-1:0]  r1_lz;
  logic             r1_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid <= 1'b0;
      r1_sign  <= 1'b0;
      r1_exp   <= '0;
      r1_value <= '0;
      r1_lz    <= '0;
      r1_zero  <= 1'b0;
    end else begin
      r1_valid <= valid_in;
      if (valid_in) begin
        r1_sign  <= sign;
        r1_exp   <= exponent;
        r1_value <= adder_value;
        r1_lz    <= w_lz;
        r1_zero  <= (adder_value == '0);
      end
    end
  end

  logic [LZ_W-1:0]          w_shift;
  logic [MAN_W:0]           w_rnd;
  logic [MAN_W-1:0]         w_frac;
  logic signed [EXP_W+1:0]  w_e;
  logic                     w_pack;
  logic                     w_ovf;
  logic                     w_unf;
  logic [EXP_W+MAN_W:0]     w_result;

  always_comb begin
    w_shift  = r1_lz - LZ_W'(1);
    // Guard bit is bit 0 with no sticky, so guard=1 is an exact tie: round to even.
    w_rnd    = {1'b0, r1_value[MAN_W:1]} + (MAN_W+1)'(r1_value[1] & r1_value[0]);
    w_frac   = '0;
    w_e      = '0;
    w_pack   = 1'b0;
    w_ovf    = 1'b0;
    w_unf    = 1'b0;
    w_result = '0;

    if (r1_exp == EXP_W'(EXP_MAX)) begin
      w_result = {r1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_ovf    = 1'b1;
    end else if (r1_zero) begin
      w_result = '0;
    end else if (r1_lz == '0) begin
      w_frac = w_rnd[MAN_W-1:0];
      w_e    = (EXP_W+2)'(r1_exp) + (EXP_W+2)'(1) + (EXP_W+2)'(w_rnd[MAN_W]);
      w_pack = 1'b1;
    end else if (r1_lz == LZ_W'(1)) begin
      w_frac = r1_value[MAN_W-1:0];
      w_e    = (EXP_W+2)'(r1_exp);
      w_pack = 1'b1;
    end else if (r1_exp <= EXP_W'(w_shift)) begin
      w_result = {r1_sign, {(EXP_W+MAN_W){1'b0}}};
      w_unf    = 1'b1;
    end else begin
      w_frac = MAN_W'(r1_value << w_shift);
      w_e    = (EXP_W+2)'(r1_exp) - (EXP_W+2)'(w_shift);
      w_pack = 1'b1;
    end

    if (w_pack) begin
      if (w_e >= c_exp_max) begin
        w_result = {r1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        w_ovf    = 1'b1;
      end else begin
        w_result = {r1_sign, w_e[EXP_W-1:0], w_frac};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      valid_out <= r1_valid;
      if (r1_valid) begin
        result    <= w_result;
        overflow  <= w_ovf;
        underflow <= w_unf;
      end
    end
  end

endmodule

`default_nettype wire
